mem_read_arbiter: RTL and testbench

Round-robin arbiter that shares the single Dijkstra memory read port (Avalon-style: read enable, address, wait_request, read-data-valid) between NUM_REQ requesters, such as node fetch, edge fetch and distance lookup. It sits between the algorithm engines and the memory interface and allows one outstanding read at a time. It issues each granted request, waits for its data and returns that data to the originating requester.

---
 rtl/dijkstra_mem_pkg.sv | 18 +
 rtl/rr_arbiter_pick.sv | 35 +++
 rtl/mem_read_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dijkstra_mem_pkg.sv
// Shared types and default widths for the Dijkstra memory read path.
package dijkstra_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  // Grant index width; at least one bit so a 1-requester build still elaborates.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_arbiter_pick
  import dijkstra_mem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               any_req
);

  int          idx;
  logic [GW-1:0] ix;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    ix      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // last_grant+1+k never exceeds 2*NUM_REQ-1, so one wrap suffices
      idx = int'(last_grant) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      ix = GW'(idx);
      if (!any_req && req[ix]) begin
        grant   = ix;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-style read port between NUM_REQ
// requesters, one outstanding read. Optional WAIT watchdog: DIJKSTRA_ARB_TIMEOUT_EN.
module mem_read_arbiter
  import dijkstra_mem_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          algorithm_clock,
  input  logic                          algorithm_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_accept,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_error,
  output logic                          mem_read_enable,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          wait_request,
  input  logic                          mem_read_ready,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  output logic                          busy
);

  localparam int GW = grant_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $fatal(1, "mem_read_arbiter: parameter out of range");
  end

  arb_state_t                           state;
  logic [GW-1:0]                        grant, last_grant, pick;
  logic                                 any_req;
  logic [NUM_REQ-1:0]                   grant_oh;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_arr;
  logic                                 timeout_hit;

  assign addr_arr = req_addr;
  assign grant_oh = NUM_REQ'(1) << grant;

  rr_arbiter_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  // Accept is the cycle memory takes the strobe, so it follows wait_request directly.
  assign req_accept = (state == ARB_ISSUE && !wait_request) ? grant_oh : '0;
  assign busy       = (state != ARB_IDLE);

`ifdef DIJKSTRA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          resp_error_q;

  always_ff @(posedge algorithm_clock) begin
    if (algorithm_reset) begin
      to_cnt <= '0;
    end else if (state == ARB_ISSUE && !wait_request) begin
      to_cnt <= '0;
    end else if (state == ARB_WAIT && !mem_read_ready && !timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ARB_WAIT) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign resp_error  = resp_error_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_error  = 1'b0;
`endif

  always_ff @(posedge algorithm_clock) begin
    if (algorithm_reset) begin
      state           <= ARB_IDLE;
      grant           <= '0;
      last_grant      <= GW'(NUM_REQ - 1);
      mem_read_enable <= 1'b0;
      mem_addr        <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
`ifdef DIJKSTRA_ARB_TIMEOUT_EN
      resp_error_q    <= 1'b0;
`endif
    end else begin
      resp_valid <= '0;
`ifdef DIJKSTRA_ARB_TIMEOUT_EN
      resp_error_q <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant           <= pick;
            mem_addr        <= addr_arr[pick];
            mem_read_enable <= 1'b1;
            state           <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (!wait_request) begin
            last_grant      <= grant;
            mem_read_enable <= 1'b0;
            mem_addr        <= '0;
            state           <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // Data arriving on the limit cycle wins over the watchdog
          if (mem_read_ready) begin
            resp_data  <= mem_read_data;
            resp_valid <= grant_oh;
            state      <= ARB_IDLE;
          end else if (timeout_hit) begin
            resp_data  <= '0;
            resp_valid <= grant_oh;
`ifdef DIJKSTRA_ARB_TIMEOUT_EN
            resp_error_q <= 1'b1;
`endif
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: expected responses queued as memory
// data is driven, popped by a negedge monitor when resp_valid pulses.
module tb_mem_read_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 16;

  logic              algorithm_clock = 1'b0;
  logic              algorithm_reset;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_accept;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_data;
  logic              resp_error;
  logic              mem_read_enable;
  logic [AW-1:0]     mem_addr;
  logic              wait_request;
  logic              mem_read_ready;
  logic [DW-1:0]     mem_read_data;
  logic              busy;

  mem_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .algorithm_clock (algorithm_clock),
    .algorithm_reset (algorithm_reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_accept      (req_accept),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_error      (resp_error),
    .mem_read_enable (mem_read_enable),
    .mem_addr        (mem_addr),
    .wait_request    (wait_request),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .busy            (busy)
  );

  always #5 algorithm_clock = ~algorithm_clock;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always @(negedge algorithm_clock) begin
    if (resp_valid !== '0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: resp_valid=%b data=%h err=%b, required no response",
                 resp_valid, resp_data, resp_error);
      end else begin
        mon_e = q.pop_front();
        if (resp_valid !== (NR'(1) << mon_e.idx) || resp_data !== mon_e.data ||
            resp_error !== mon_e.err) begin
          bad++;
          $display("FAIL resp_scoreboard: got valid=%b data=%h err=%b, required valid=%b data=%h err=%b",
                   resp_valid, resp_data, resp_error, NR'(1) << mon_e.idx, mon_e.data, mon_e.err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge algorithm_clock);
    #1;
  endtask

  task automatic apply_reset();
    algorithm_reset = 1'b1;
    req_valid       = '0;
    req_addr        = '0;
    wait_request    = 1'b0;
    mem_read_ready  = 1'b0;
    mem_read_data   = '0;
    tick();
    tick();
    algorithm_reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    algorithm_reset = 1'b1;
    req_valid = 4'b1111;
    tick();
    @(negedge algorithm_clock);
    total++;
    if ({req_accept, resp_valid, resp_data, resp_error, mem_read_enable, mem_addr, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: acc=%b rv=%b rd=%h re=%b en=%b addr=%h busy=%b, required all 0",
               req_accept, resp_valid, resp_data, resp_error, mem_read_enable, mem_addr, busy);
    end
    req_valid = '0;
    tick();
    algorithm_reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    req_addr[0*AW +: AW] = 32'h100;
    req_valid = 4'b0001;
    @(negedge algorithm_clock);
    total++;
    if (mem_read_enable !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_cycle0: en=%b busy=%b, required 0 0", mem_read_enable, busy);
    end
    tick();
    @(negedge algorithm_clock);
    total++;
    if (mem_read_enable !== 1'b1 || mem_addr !== 32'h100 || req_accept !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_cycle1: en=%b addr=%h acc=%b busy=%b, required 1 100 0001 1",
               mem_read_enable, mem_addr, req_accept, busy);
    end
    tick();
    req_valid      = '0;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h00AB;
    q.push_back('{0, 16'h00AB, 1'b0});
    @(negedge algorithm_clock);
    total++;
    if (mem_read_enable !== 1'b0 || mem_addr !== '0 || req_accept !== '0) begin
      bad++;
      $display("FAIL single_cycle2: en=%b addr=%h acc=%b, required 0 0 0", mem_read_enable, mem_addr, req_accept);
    end
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    @(negedge algorithm_clock);
    total++;
    if (resp_valid !== 4'b0001 || resp_data !== 16'h00AB || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_cycle3: rv=%b rd=%h busy=%b, required 0001 00ab 0", resp_valid, resp_data, busy);
    end
    tick();
    @(negedge algorithm_clock);
    total++;
    if (resp_valid !== '0) begin
      bad++;
      $display("FAIL single_pulse: rv=%b, required 0000", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int cyc;
    apply_reset();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 32'h1000 + 32'(i) * 32'h40;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cyc = 0;
      @(negedge algorithm_clock);
      cyc++;
      while (req_accept === '0 && cyc < 10) begin
        @(negedge algorithm_clock);
        cyc++;
      end
      total++;
      if (req_accept !== (NR'(1) << exp_order[n]) || mem_read_enable !== 1'b1 ||
          mem_addr !== (32'h1000 + 32'(exp_order[n]) * 32'h40) || cyc != 2) begin
        bad++;
        $display("FAIL rr_grant%0d: acc=%b addr=%h en=%b cyc=%0d, required acc=%b addr=%h en=1 cyc=2",
                 n, req_accept, mem_addr, mem_read_enable, cyc, NR'(1) << exp_order[n],
                 32'h1000 + 32'(exp_order[n]) * 32'h40);
      end
      tick();
      mem_read_ready = 1'b1;
      mem_read_data  = 16'h5A00 + 16'(n);
      q.push_back('{exp_order[n], 16'h5A00 + 16'(n), 1'b0});
      tick();
      mem_read_ready = 1'b0;
      mem_read_data  = '0;
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_wait_stall();
    int accepts = 0;
    apply_reset();
    req_addr[2*AW +: AW] = 32'h000BEEF0;
    req_valid    = 4'b0100;
    wait_request = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge algorithm_clock);
      if (req_accept !== '0) accepts++;
      total++;
      if (mem_read_enable !== 1'b1 || mem_addr !== 32'h000BEEF0) begin
        bad++;
        $display("FAIL stall_hold%0d: en=%b addr=%h, required 1 000beef0", i, mem_read_enable, mem_addr);
      end
      tick();
    end
    wait_request = 1'b0;
    @(negedge algorithm_clock);
    total++;
    if (req_accept !== 4'b0100 || accepts != 0 || mem_read_enable !== 1'b1 || mem_addr !== 32'h000BEEF0) begin
      bad++;
      $display("FAIL stall_accept: acc=%b early_accepts=%0d en=%b addr=%h, required 0100 0 1 000beef0",
               req_accept, accepts, mem_read_enable, mem_addr);
    end
    tick();
    req_valid      = '0;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1234;
    q.push_back('{2, 16'h1234, 1'b0});
    @(negedge algorithm_clock);
    total++;
    if (req_accept !== '0) begin
      bad++;
      $display("FAIL stall_single_pulse: acc=%b, required 0000", req_accept);
    end
    tick();
    mem_read_ready = 1'b0;
    @(negedge algorithm_clock);
    total++;
    if (resp_valid !== 4'b0100 || resp_data !== 16'h1234) begin
      bad++;
      $display("FAIL stall_resp: rv=%b rd=%h, required 0100 1234", resp_valid, resp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_addr[1*AW +: AW] = 32'h2000;
    req_valid = 4'b0010;
    tick();
    @(negedge algorithm_clock);
    total++;
    if (req_accept !== 4'b0010) begin
      bad++;
      $display("FAIL rstmid_accept: acc=%b, required 0010", req_accept);
    end
    tick();
    req_valid       = '0;
    algorithm_reset = 1'b1;
    tick();
    algorithm_reset = 1'b0;
    tick();
    tick();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    @(negedge algorithm_clock);
    total++;
    if ({req_accept, resp_valid, resp_data, resp_error, mem_read_enable, mem_addr, busy} !== '0) begin
      bad++;
      $display("FAIL rstmid_quiet: acc=%b rv=%b rd=%h re=%b en=%b addr=%h busy=%b, required all 0",
               req_accept, resp_valid, resp_data, resp_error, mem_read_enable, mem_addr, busy);
    end
    req_addr[0*AW +: AW] = 32'h3000;
    req_addr[2*AW +: AW] = 32'h3100;
    req_valid = 4'b0101;
    tick();
    @(negedge algorithm_clock);
    total++;
    if (req_accept !== 4'b0001 || mem_addr !== 32'h3000) begin
      bad++;
      $display("FAIL rstmid_first_prio: acc=%b addr=%h, required 0001 00003000", req_accept, mem_addr);
    end
    tick();
    req_valid      = '0;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h0F0F;
    q.push_back('{0, 16'h0F0F, 1'b0});
    tick();
    mem_read_ready = 1'b0;
    tick();
  endtask

  task automatic test_stray_ready();
    apply_reset();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h7777;
    tick();
    tick();
    mem_read_ready = 1'b0;
    req_addr[0*AW +: AW] = 32'h300;
    req_valid = 4'b0001;
    tick();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h6666;
    @(negedge algorithm_clock);
    total++;
    if (req_accept !== 4'b0001) begin
      bad++;
      $display("FAIL stray_accept: acc=%b, required 0001", req_accept);
    end
    tick();
    req_valid      = '0;
    mem_read_ready = 1'b0;
    tick();
    @(negedge algorithm_clock);
    total++;
    if (busy !== 1'b1 || resp_valid !== '0) begin
      bad++;
      $display("FAIL stray_ignored: busy=%b rv=%b, required 1 0000", busy, resp_valid);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h4242;
    q.push_back('{0, 16'h4242, 1'b0});
    tick();
    mem_read_ready = 1'b0;
    @(negedge algorithm_clock);
    total++;
    if (resp_valid !== 4'b0001 || resp_data !== 16'h4242) begin
      bad++;
      $display("FAIL stray_resp: rv=%b rd=%h, required 0001 4242", resp_valid, resp_data);
    end
    tick();
  endtask

`ifdef DIJKSTRA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      req_addr[0*AW +: AW] = 32'h400;
      req_valid = 4'b0001;
      tick();
      tick();
      req_valid = '0;
      for (int i = 0; i < 7; i++) begin
        @(negedge algorithm_clock);
        total++;
        if (busy !== 1'b1 || resp_valid !== '0) begin
          bad++;
          $display("FAIL to_wait%0d_%0d: busy=%b rv=%b, required 1 0000", pass, i, busy, resp_valid);
        end
        tick();
      end
      if (pass == 1) begin
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h0C0C;
        q.push_back('{0, 16'h0C0C, 1'b0});
      end else begin
        q.push_back('{0, 16'h0000, 1'b1});
      end
      tick();
      mem_read_ready = 1'b0;
      mem_read_data  = '0;
      @(negedge algorithm_clock);
      total++;
      if (resp_valid !== 4'b0001 || resp_error !== (pass == 0) ||
          resp_data !== ((pass == 0) ? 16'h0000 : 16'h0C0C) || busy !== 1'b0) begin
        bad++;
        $display("FAIL to_resp%0d: rv=%b err=%b rd=%h busy=%b, required 0001 %0d %h 0",
                 pass, resp_valid, resp_error, resp_data, busy, pass == 0,
                 (pass == 0) ? 16'h0000 : 16'h0C0C);
      end
      tick();
    end
  endtask
`else
  task automatic test_no_timeout();
    apply_reset();
    req_addr[3*AW +: AW] = 32'h500;
    req_valid = 4'b1000;
    tick();
    tick();
    req_valid = '0;
    repeat (20) tick();
    @(negedge algorithm_clock);
    total++;
    if (busy !== 1'b1 || resp_valid !== '0 || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL nto_wait: busy=%b rv=%b err=%b, required 1 0000 0", busy, resp_valid, resp_error);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hA5A5;
    q.push_back('{3, 16'hA5A5, 1'b0});
    tick();
    mem_read_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wait_stall();
    test_reset_mid();
    test_stray_ready();
`ifdef DIJKSTRA_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
